// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - frame-tick and keyboard interrupt source with IACK/IEND handshake
module interrupt_controller #(
    parameter int FRAME_DIV = 833333,
    parameter int CNT_W     = 20,
    parameter int KEY_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KBD_VALID,
    input  logic [7:0] KBD_CODE,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [1:0] INT_IRQ,
    output logic [7:0] KBD_KEY,
    output logic       IN_SERVICE,
    output logic       FRAME_OVERRUN,
    output logic       KEY_OVERRUN
);

    localparam int AW = $clog2(KEY_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IRQ_FRAME = 2'd0;
    localparam logic [1:0] IRQ_KEY   = 2'd1;
    localparam logic [1:0] IRQ_BUSY  = 2'd2;
    localparam logic [1:0] IRQ_IDLE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ_FRAME,
        S_REQ_KEY,
        S_SERVICE
    } state_t;

    state_t         state_q;
    logic [1:0]     irq_q;
    logic [7:0]     key_q;
    logic           in_svc_q;

    logic [CNT_W-1:0] div_q, div_d;
    logic             tick;
    logic             frame_pend_q, frame_pend_d;
    logic             frame_ovr_q, frame_ovr_d;

    logic [7:0]    mem_q [KEY_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_ovr_q, key_ovr_d;

    logic frame_clr, key_pop, key_push, fifo_full, fifo_empty;

    // Acknowledge is only meaningful while a request is on the bus.
    assign frame_clr  = (state_q == S_REQ_FRAME) && INT_IACK;
    assign key_pop    = (state_q == S_REQ_KEY) && INT_IACK;
    assign fifo_full  = (cnt_q == CW'(KEY_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign key_push   = KBD_VALID && (!fifo_full || key_pop);

    assign tick  = (div_q == CNT_W'(FRAME_DIV - 1));
    assign div_d = tick ? '0 : div_q + CNT_W'(1);

    always_comb begin
        frame_pend_d = frame_pend_q;
        frame_ovr_d  = frame_ovr_q;
        if (tick) begin
            frame_pend_d = 1'b1;
            if (frame_pend_q && !frame_clr)
                frame_ovr_d = 1'b1;
        end else if (frame_clr) begin
            frame_pend_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        key_ovr_d = key_ovr_q;
        if (key_push && !key_pop)
            cnt_d = cnt_q + CW'(1);
        else if (!key_push && key_pop)
            cnt_d = cnt_q - CW'(1);
        if (KBD_VALID && !key_push)
            key_ovr_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q        <= '0;
            frame_pend_q <= 1'b0;
            frame_ovr_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            key_ovr_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            frame_pend_q <= frame_pend_d;
            frame_ovr_q  <= frame_ovr_d;
            cnt_q        <= cnt_d;
            key_ovr_q    <= key_ovr_d;
            if (key_push) begin
                mem_q[wr_ptr_q] <= KBD_CODE;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (key_pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Request FSM; KBD_KEY is only reloaded when a key request is raised.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            irq_q    <= IRQ_IDLE;
            key_q    <= 8'h00;
            in_svc_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_pend_q) begin
                        state_q <= S_REQ_FRAME;
                        irq_q   <= IRQ_FRAME;
                    end else if (!fifo_empty) begin
                        state_q <= S_REQ_KEY;
                        irq_q   <= IRQ_KEY;
                        key_q   <= mem_q[rd_ptr_q];
                    end
                end
                S_REQ_FRAME, S_REQ_KEY: begin
                    if (INT_IACK) begin
                        state_q  <= S_SERVICE;
                        irq_q    <= IRQ_BUSY;
                        in_svc_q <= 1'b1;
                    end
                end
                S_SERVICE: begin
                    if (INT_IEND) begin
                        state_q  <= S_IDLE;
                        irq_q    <= IRQ_IDLE;
                        in_svc_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    irq_q    <= IRQ_IDLE;
                    in_svc_q <= 1'b0;
                end
            endcase
        end
    end

    assign INT_IRQ       = irq_q;
    assign KBD_KEY       = key_q;
    assign IN_SERVICE    = in_svc_q;
    assign FRAME_OVERRUN = frame_ovr_q;
    assign KEY_OVERRUN   = key_ovr_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized and directed bench for interrupt_controller against a behavioural model
module tb_interrupt_controller;

    localparam int FRAME_DIV = 16;
    localparam int CNT_W     = 8;
    localparam int KEY_DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       KBD_VALID = 1'b0;
    logic [7:0] KBD_CODE = 8'h00;
    logic       INT_IACK = 1'b0;
    logic       INT_IEND = 1'b0;
    logic [1:0] INT_IRQ;
    logic [7:0] KBD_KEY;
    logic       IN_SERVICE;
    logic       FRAME_OVERRUN;
    logic       KEY_OVERRUN;

    int errors = 0;
    int checks = 0;
    int t = 0;

    interrupt_controller #(
        .FRAME_DIV(FRAME_DIV),
        .CNT_W    (CNT_W),
        .KEY_DEPTH(KEY_DEPTH)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .KBD_VALID    (KBD_VALID),
        .KBD_CODE     (KBD_CODE),
        .INT_IACK     (INT_IACK),
        .INT_IEND     (INT_IEND),
        .INT_IRQ      (INT_IRQ),
        .KBD_KEY      (KBD_KEY),
        .IN_SERVICE   (IN_SERVICE),
        .FRAME_OVERRUN(FRAME_OVERRUN),
        .KEY_OVERRUN  (KEY_OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Model: irq code doubles as the request phase (3 idle, 0/1 requesting, 2 serving).
    bit         m_valid = 1'b0;
    int         m_cyc;
    bit         m_pend;
    int         m_irq;
    logic [7:0] m_key;
    bit         m_fo, m_ko;
    logic [7:0] kq[$];

    always @(posedge CLK) begin
        bit tick, clr, pop, full;
        int nirq;
        if (RESET) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            m_pend  = 1'b0;
            m_irq   = 3;
            m_key   = 8'h00;
            m_fo    = 1'b0;
            m_ko    = 1'b0;
            kq.delete();
        end else if (m_valid) begin
            tick = ((m_cyc % FRAME_DIV) == FRAME_DIV - 1);
            m_cyc++;
            clr  = (m_irq == 0) && INT_IACK;
            pop  = (m_irq == 1) && INT_IACK;
            nirq = m_irq;
            if (m_irq == 3) begin
                if (m_pend) nirq = 0;
                else if (kq.size() > 0) begin
                    nirq  = 1;
                    m_key = kq[0];
                end
            end else if (m_irq == 2) begin
                if (INT_IEND) nirq = 3;
            end else if (INT_IACK) begin
                nirq = 2;
            end
            full = (kq.size() == KEY_DEPTH);
            if (pop) void'(kq.pop_front());
            if (KBD_VALID) begin
                if (!full || pop) kq.push_back(KBD_CODE);
                else m_ko = 1'b1;
            end
            if (tick) begin
                if (!m_pend || clr) m_pend = 1'b1;
                else m_fo = 1'b1;
            end else if (clr) begin
                m_pend = 1'b0;
            end
            m_irq = nirq;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            checks++;
            if (INT_IRQ !== 2'(m_irq) || KBD_KEY !== m_key || IN_SERVICE !== (m_irq == 2)
                || FRAME_OVERRUN !== m_fo || KEY_OVERRUN !== m_ko) begin
                errors++;
                $display("FAIL model t=%0d: irq=%0d key=%02h svc=%0b fo=%0b ko=%0b, required irq=%0d key=%02h svc=%0b fo=%0b ko=%0b",
                         t, INT_IRQ, KBD_KEY, IN_SERVICE, FRAME_OVERRUN, KEY_OVERRUN,
                         m_irq, m_key, (m_irq == 2), m_fo, m_ko);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        t = 0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (INT_IRQ == 2'd3 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (INT_IRQ == 2'd3) begin
            errors++;
            $display("FAIL %s: no request within 64 cycles, irq=%0d", name, INT_IRQ);
        end
    endtask

    task automatic ack_end();
        INT_IACK = 1'b1;
        step();
        INT_IACK = 1'b0;
        INT_IEND = 1'b1;
        step();
        INT_IEND = 1'b0;
    endtask

    logic [7:0] got_keys[$];
    bit         saw_key;

    initial begin
        @(posedge CLK);
        #1;
        do_reset();
        chk("reset_irq", INT_IRQ, 3);
        chk("reset_key", KBD_KEY, 0);
        chk("reset_svc", IN_SERVICE, 0);

        // First frame: idle through cycle 16, request at 17.
        while (t < 16) step();
        chk("frame1_pre", INT_IRQ, 3);
        step();
        chk("frame1_irq", INT_IRQ, 0);
        INT_IACK = 1'b1;
        step();
        INT_IACK = 1'b0;
        chk("frame1_busy", INT_IRQ, 2);
        chk("frame1_svc", IN_SERVICE, 1);
        INT_IEND = 1'b1;
        step();
        INT_IEND = 1'b0;
        chk("frame1_end", INT_IRQ, 3);
        while (t < 32) step();
        chk("frame2_pre", INT_IRQ, 3);
        step();
        chk("frame2_irq", INT_IRQ, 0);
        ack_end();

        // Single key while idle (t=35).
        KBD_VALID = 1'b1;
        KBD_CODE  = 8'h20;
        step();
        KBD_VALID = 1'b0;
        step();
        chk("key20_irq", INT_IRQ, 1);
        chk("key20_key", KBD_KEY, 8'h20);
        ack_end();
        chk("key20_idle", INT_IRQ, 3);
        chk("key20_hold", KBD_KEY, 8'h20);

        // Key and frame both pending: frame first.
        while (t < 47) step();
        KBD_VALID = 1'b1;
        KBD_CODE  = 8'h1C;
        step();
        KBD_VALID = 1'b0;
        step();
        chk("prio_frame", INT_IRQ, 0);
        ack_end();
        chk("prio_idle", INT_IRQ, 3);
        step();
        chk("prio_key_irq", INT_IRQ, 1);
        chk("prio_key", KBD_KEY, 8'h1C);
        ack_end();

        // Five keys while stalled in service.
        wait_req("stall_req");
        INT_IACK = 1'b1;
        step();
        INT_IACK = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            KBD_VALID = 1'b1;
            KBD_CODE  = 8'(i);
            step();
        end
        KBD_VALID = 1'b0;
        chk("key_overrun", KEY_OVERRUN, 1);
        chk("stall_svc", INT_IRQ, 2);
        INT_IEND = 1'b1;
        step();
        INT_IEND = 1'b0;
        got_keys.delete();
        for (int r = 0; r < 10 && got_keys.size() < 4; r++) begin
            wait_req("drain_req");
            if (INT_IRQ == 2'd1) got_keys.push_back(KBD_KEY);
            ack_end();
        end
        chk("drain_count", got_keys.size(), 4);
        for (int i = 0; i < got_keys.size(); i++)
            chk("drain_order", got_keys[i], i + 1);
        saw_key = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (INT_IRQ == 2'd1) saw_key = 1'b1;
            step();
        end
        chk("drain_empty", saw_key, 0);

        // Withheld frame acknowledge across two terminal counts.
        wait_req("ovr_req");
        chk("ovr_is_frame", INT_IRQ, 0);
        repeat (35) step();
        chk("frame_overrun", FRAME_OVERRUN, 1);
        chk("ovr_held", INT_IRQ, 0);
        ack_end();
        chk("ovr_idle", INT_IRQ, 3);

        // Misplaced handshake pulses, then reset mid-service.
        wait_req("ign_req");
        INT_IEND = 1'b1;
        step();
        INT_IEND = 1'b0;
        chk("iend_in_req", INT_IRQ, 0);
        INT_IACK = 1'b1;
        step();
        chk("ack_busy", INT_IRQ, 2);
        step();
        INT_IACK = 1'b0;
        chk("iack_in_svc", INT_IRQ, 2);
        chk("iack_in_svc_flag", IN_SERVICE, 1);
        do_reset();
        chk("rst_irq", INT_IRQ, 3);
        chk("rst_svc", IN_SERVICE, 0);
        chk("rst_fo", FRAME_OVERRUN, 0);
        chk("rst_ko", KEY_OVERRUN, 0);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            KBD_VALID = ($urandom_range(0, 4) == 0);
            KBD_CODE  = 8'($urandom);
            INT_IACK  = ($urandom_range(0, 2) == 0);
            INT_IEND  = ($urandom_range(0, 3) == 0);
            RESET     = ($urandom_range(0, 499) == 0);
            step();
        end
        RESET     = 1'b0;
        KBD_VALID = 1'b0;
        INT_IACK  = 1'b0;
        INT_IEND  = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
